// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin, frame-locked arbiter sharing one UART transmitter among
// NUM_REQ byte producers. A grant is held for a whole frame, which ends
// when the owner's byte marked Req_Last has left the UART. Each byte is
// handed over through the transmitter's start/busy handshake. A gap
// timeout releases a grant whose owner stops supplying bytes mid-frame.
//
// Ports
//   clk, reset_b      : clock, synchronous active-low reset
//   Req_Valid[i]      : requester i presents a byte
//   Req_Last[i]       : that byte ends requester i's frame
//   Req_Data          : requester i's byte at [i*WORD_SIZE +: WORD_SIZE]
//   Req_Ready[i]      : one-cycle pulse, requester i's byte consumed
//   TX_Start          : one-cycle start pulse to the UART TX controller
//   TX_Data           : byte for the transmitter (valid with TX_Start)
//   TX_Busy           : UART busy, high from the cycle after TX_Start
//   Grant_Valid       : a frame grant is held
//   Grant_Id          : index of the granted requester
//   Frame_Abort       : one-cycle pulse when the gap timeout drops a grant

module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned REQ_ID_WIDTH = 2,
   parameter int unsigned WORD_SIZE    = 8,
   parameter int unsigned GAP_TIMEOUT  = 1023,
   parameter int unsigned GAP_WIDTH    = 10
) (
   input  logic                           clk,
   input  logic                           reset_b,
   input  logic [NUM_REQ-1:0]             Req_Valid,
   input  logic [NUM_REQ-1:0]             Req_Last,
   input  logic [NUM_REQ*WORD_SIZE-1:0]   Req_Data,
   output logic [NUM_REQ-1:0]             Req_Ready,
   output logic                           TX_Start,
   output logic [WORD_SIZE-1:0]           TX_Data,
   input  logic                           TX_Busy,
   output logic                           Grant_Valid,
   output logic [REQ_ID_WIDTH-1:0]        Grant_Id,
   output logic                           Frame_Abort
);

   localparam int unsigned LAST_ID = NUM_REQ - 1;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_SEND      = 2'd1,
      ST_WAIT_ACK  = 2'd2,
      ST_WAIT_DONE = 2'd3
   } state_t;

   state_t                    state_q, state_d;
   logic [REQ_ID_WIDTH-1:0]   ptr_q, ptr_d;
   logic [REQ_ID_WIDTH-1:0]   grant_id_q, grant_id_d;
   logic [GAP_WIDTH-1:0]      gap_q, gap_d;
   logic                      last_q, last_d;
   logic                      grant_valid_q, grant_valid_d;

   // Per-requester byte view of the flat data bus
   logic [WORD_SIZE-1:0]      req_word [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_word
      assign req_word[gi] = Req_Data[gi*WORD_SIZE +: WORD_SIZE];
   end

   // Granted requester's handshake signals
   logic                      g_valid;
   logic                      g_last;
   logic [WORD_SIZE-1:0]      g_data;

   assign g_valid = Req_Valid[grant_id_q];
   assign g_last  = Req_Last[grant_id_q];
   assign g_data  = req_word[grant_id_q];

   // Pointer value after the current frame ends: one past the owner
   logic [REQ_ID_WIDTH-1:0]   next_ptr;

   assign next_ptr = (grant_id_q == REQ_ID_WIDTH'(LAST_ID)) ? '0
                                                            : grant_id_q + REQ_ID_WIDTH'(1);

   // Gap count for this cycle; saturates so a disabled timeout never wraps
   logic [GAP_WIDTH-1:0]      gap_inc;

   assign gap_inc = (gap_q == '1) ? gap_q : gap_q + GAP_WIDTH'(1);

   // Round-robin search starting at ptr, wrapping modulo NUM_REQ
   logic                      win_found;
   logic [REQ_ID_WIDTH-1:0]   win_id;
   logic [REQ_ID_WIDTH-1:0]   cand;

   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      cand      = ptr_q;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!win_found && Req_Valid[cand]) begin
            win_found = 1'b1;
            win_id    = cand;
         end
         cand = (cand == REQ_ID_WIDTH'(LAST_ID)) ? '0 : cand + REQ_ID_WIDTH'(1);
      end
   end

   // Next-state and handshake outputs
   logic                      tx_start_c;
   logic [NUM_REQ-1:0]        req_ready_c;
   logic [WORD_SIZE-1:0]      tx_data_c;
   logic                      frame_abort_c;

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      grant_id_d    = grant_id_q;
      gap_d         = gap_q;
      last_d        = last_q;
      tx_start_c    = 1'b0;
      req_ready_c   = '0;
      tx_data_c     = '0;
      frame_abort_c = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               grant_id_d = win_id;
               gap_d      = '0;
               state_d    = ST_SEND;
            end
         end

         ST_SEND: begin
            tx_data_c = g_data;
            if (g_valid) begin
               // A present byte waits on a busy UART without counting as a gap
               if (!TX_Busy) begin
                  tx_start_c              = 1'b1;
                  req_ready_c[grant_id_q] = 1'b1;
                  last_d                  = g_last;
                  state_d                 = ST_WAIT_ACK;
               end
            end else begin
               gap_d = gap_inc;
               if ((GAP_TIMEOUT != 0) && (gap_inc == GAP_WIDTH'(GAP_TIMEOUT))) begin
                  frame_abort_c = 1'b1;
                  ptr_d         = next_ptr;
                  state_d       = ST_IDLE;
               end
            end
         end

         ST_WAIT_ACK: begin
            if (TX_Busy) begin
               state_d = ST_WAIT_DONE;
            end
         end

         ST_WAIT_DONE: begin
            if (!TX_Busy) begin
               if (last_q) begin
                  ptr_d   = next_ptr;
                  state_d = ST_IDLE;
               end else begin
                  gap_d   = '0;
                  state_d = ST_SEND;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      grant_valid_d = (state_d != ST_IDLE);
   end

   // State and grant registers
   always_ff @(posedge clk) begin
      if (!reset_b) begin
         state_q       <= ST_IDLE;
         ptr_q         <= '0;
         grant_id_q    <= '0;
         gap_q         <= '0;
         last_q        <= 1'b0;
         grant_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         grant_id_q    <= grant_id_d;
         gap_q         <= gap_d;
         last_q        <= last_d;
         grant_valid_q <= grant_valid_d;
      end
   end

   assign TX_Start    = tx_start_c;
   assign Req_Ready   = req_ready_c;
   assign TX_Data     = tx_data_c;
   assign Frame_Abort = frame_abort_c;
   assign Grant_Valid = grant_valid_q;
   assign Grant_Id    = grant_id_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin, frame-locked arbiter that shares one UART transmitter between `NUM_REQ` byte producers, such as the ping-data packer, status reporter and command-ack generator. It sequences the transmitter's start/busy handshake one byte at a time. It holds the grant for a whole frame until the requester marks the last byte. A gap timeout releases a grant whose owner stalls. The block sits between the producer blocks and the UART TX datapath/controller pair.

## Interface
- `NUM_REQ`, default 4: number of requesters (2..8).
- `REQ_ID_WIDTH`, default 2: width of `Grant_Id`, equal to ceil(log2(`NUM_REQ`)).
- `WORD_SIZE`, default 8: bits per UART word.
- `GAP_TIMEOUT`, default 1023: idle cycles allowed mid-frame before abort. A value of 0 disables the timeout.
- `GAP_WIDTH`, default 10: gap counter width.
- `clk`, input, 1: single clock for the block.
- `reset_b`, input, 1: reset, synchronous and active-low.
- `Req_Valid`, input, `NUM_REQ`: requester i has a byte on its `Req_Data` slice.
- `Req_Last`, input, `NUM_REQ`: the byte from requester i is the last of its frame. Qualified by `Req_Valid`.
- `Req_Data`, input, `NUM_REQ*WORD_SIZE`: requester i's byte is at `[i*WORD_SIZE +: WORD_SIZE]`.
- `Req_Ready`, output, `NUM_REQ`: one-hot, one-cycle pulse; requester i's byte was consumed this cycle.
- `TX_Start`, output, 1: one-cycle pulse to the UART TX controller.
- `TX_Data`, output, `WORD_SIZE`: byte for the transmitter. Valid when `TX_Start` is 1.
- `TX_Busy`, input, 1: from the UART TX controller. It is 1 from the cycle after `TX_Start` through the end of the stop bit.
- `Grant_Valid`, output, 1: a frame grant is held.
- `Grant_Id`, output, `REQ_ID_WIDTH`: index of the granted requester.
- `Frame_Abort`, output, 1: one-cycle pulse when a grant is released by the gap timeout.

## Operation
- States:
  - IDLE: no grant.
  - SEND: granted; waiting for a byte and for the TX to be idle.
  - WAIT_ACK: start issued; waiting for `TX_Busy` to rise.
  - WAIT_DONE: byte in flight; waiting for `TX_Busy` to fall.
- Round-robin pointer `ptr` (`REQ_ID_WIDTH` bits):
  - Search order is `ptr`, `ptr`+1, … mod `NUM_REQ`; the first index with `Req_Valid` set wins.
  - On frame completion or abort, `ptr` becomes `g`+1 mod `NUM_REQ`, where `g` is the granted index.
- IDLE:
  - If any `Req_Valid` is set, register the winner into `Grant_Id`, clear the gap counter and go to SEND.
  - Otherwise stay in IDLE.
- SEND, when `Req_Valid[g]` is 1 and `TX_Busy` is 0:
  - Combinationally assert `TX_Start`, set `Req_Ready[g]` to 1 and drive `TX_Data` from slice `g`.
  - Register `last_q` from `Req_Last[g]` and go to WAIT_ACK.
- SEND, when `Req_Valid[g]` is 0:
  - Increment the gap counter.
  - When the counter equals `GAP_TIMEOUT` (and `GAP_TIMEOUT` is not 0), pulse `Frame_Abort`, advance `ptr` and go to IDLE.
- WAIT_ACK: go to WAIT_DONE when `TX_Busy` is 1.
- WAIT_DONE, when `TX_Busy` is 0:
  - If `last_q` is 1, advance `ptr` and go to IDLE.
  - Otherwise clear the gap counter and go to SEND.
- Frame lock: other requesters' `Req_Valid` is ignored from IDLE exit until the return to IDLE.
- `TX_Data` is 0 outside SEND. `Req_Ready` is all zero except in the consuming cycle.
- `Grant_Valid` is 1 in SEND, WAIT_ACK and WAIT_DONE.
- The granted requester deasserting `Req_Valid` mid-frame only pauses the frame. It does not drop the grant.
- `Req_Last` on a single-byte frame returns the block to IDLE after that byte.

## Timing
- Reset (`reset_b` is 0 at a clock edge):
  - State goes to IDLE; `ptr`, `Grant_Id`, the gap counter and `last_q` go to 0.
  - All outputs are 0 from the next cycle.
- Reset mid-frame drops the grant immediately. A byte already inside the UART is not aborted by this block.
- Request latency: if `Req_Valid` is sampled in IDLE at edge k, the block is in SEND at cycle k+1. `TX_Start` and `Req_Ready` are high during cycle k+1 when `TX_Busy` is 0.
- Per-byte overhead beyond UART frame time:
  - 1 cycle in WAIT_ACK.
  - 1 cycle for the WAIT_DONE→SEND edge.
  - Back-to-back bytes in one frame: the next `TX_Start` is in the first cycle after `TX_Busy` falls plus 1.
- Grant turnaround: after the last byte, IDLE takes 1 cycle and the next grant's SEND follows 1 cycle later.
- Gap timeout: `Frame_Abort` is asserted in the `GAP_TIMEOUT`-th consecutive SEND cycle with `Req_Valid[g]` at 0. The block is in IDLE the next cycle.
- If `Req_Valid[g]` rises in the same cycle the count hits `GAP_TIMEOUT`, the byte is consumed. Consumption takes priority over abort.

## Test plan
- Single requester: req 2 sends a 3-byte frame 0xA5, 0x5A, 0xFF (last on 0xFF). `TX_Busy` is modelled as 100 cycles. Expect 3 `TX_Start` pulses with those bytes, `Grant_Id`=2 throughout, then IDLE and `ptr`=3.
- Contention: reqs 0, 1 and 3 all valid with 1-byte frames from reset. Expect grant order 0, 1, 3, then 0 again on re-request. No two grants overlap.
- Frame lock: req 1 holds a 4-byte frame while req 0 is asserted continuously. Expect all 4 of req 1's bytes before any req 0 byte.
- Gap timeout: `GAP_TIMEOUT`=16; req 0 sends 1 non-last byte, then drops `Req_Valid`. Expect the `Frame_Abort` pulse 16 SEND cycles later, then IDLE, then a grant to the next valid requester.
- Reset mid-frame: `reset_b` is 0 for 1 cycle during WAIT_DONE of byte 2 of 4. Expect all outputs 0, `ptr`=0, and re-arbitration from req 0 after release.
- Busy stall: hold `TX_Busy`=1 on entry to SEND. Expect no `TX_Start`, no `Req_Ready` and no gap counting while `Req_Valid[g]` is 1.
